// File: rtl/ram2video_multimode.sv
// ram2video_multimode
// Raster timing generator and circular line-buffer reader. Produces hsync,
// vsync and DrawArea from parameters, issues line-buffer read addresses with
// optional horizontal pixel repeat, line doubling and an extra line per frame,
// and aligns colour/sync outputs with the 2-clock RAM read latency.
// Optional feature: define RAM2VIDEO_TESTPATTERN_EN to add a test_mode input
// that replaces the RAM colour with eight vertical colour bars.
module ram2video_multimode #(
    parameter int H_VISIBLE      = 720,
    parameter int H_TOTAL        = 858,
    parameter int H_SYNC_START   = 736,
    parameter int H_SYNC_WIDTH   = 62,
    parameter int V_VISIBLE      = 480,
    parameter int V_TOTAL        = 525,
    parameter int V_SYNC_START   = 489,
    parameter int V_SYNC_WIDTH   = 6,
    parameter int H_OFFSET       = 40,
    parameter int V_OFFSET       = 0,
    parameter int SRC_LINE_WIDTH = 640,
    parameter int BUFFER_LINES   = 4,
    parameter int ADDR_BITS      = 12,
    parameter int DATA_BITS      = 24,
    parameter bit HSYNC_POL      = 1'b0,
    parameter bit VSYNC_POL      = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   starttrigger,
    input  logic                   pixel_repeat,
    input  logic                   line_doubler,
    input  logic                   add_line,
`ifdef RAM2VIDEO_TESTPATTERN_EN
    input  logic                   test_mode,
`endif
    input  logic [DATA_BITS-1:0]   rddata,
    output logic [ADDR_BITS-1:0]   rdaddr,
    output logic [DATA_BITS/3-1:0] red,
    output logic [DATA_BITS/3-1:0] green,
    output logic [DATA_BITS/3-1:0] blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   DrawArea,
    output logic                   frame_start,
    output logic                   line_done,
    output logic                   running
);

    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL + 1);
    localparam int CW = DATA_BITS / 3;
    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST_STD = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST_ADD = YW'(V_TOTAL);

    typedef enum logic {ST_WAIT, ST_RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic          v1;
    logic [XW-1:0] x2;
    logic [YW-1:0] y2;
    logic          v2;
    logic          pixel_repeat_q;
    logic          line_doubler_q;
    logic          add_line_q;
    logic          mode_changed;
    logic [YW-1:0] y_last;
    int            dx;
    int            dy;
    int            sx;
    int            sy;
    logic          in0;
    int            x2i;
    int            y2i;
    logic          in2;
    logic          hs_act;
    logic          vs_act;
`ifdef RAM2VIDEO_TESTPATTERN_EN
    localparam int BAR_W_RAW = (H_VISIBLE - 2 * H_OFFSET) / 8;
    localparam int BAR_W     = (BAR_W_RAW < 1) ? 1 : BAR_W_RAW;
    int            bar;
    logic [2:0]    bar_rgb;
`endif

    // Border region shared by the address stage and the colour stage
    function automatic logic in_border(input int px, input int py);
        return (px >= H_OFFSET) && (px < H_VISIBLE - H_OFFSET) &&
               (py >= V_OFFSET) && (py < V_VISIBLE - V_OFFSET);
    endfunction

    // Registered copy of the mode inputs; a difference means the mode changed
    always_ff @(posedge clock) begin
        pixel_repeat_q <= pixel_repeat;
        line_doubler_q <= line_doubler;
        add_line_q     <= add_line;
    end

    assign mode_changed = (pixel_repeat != pixel_repeat_q) ||
                          (line_doubler != line_doubler_q) ||
                          (add_line != add_line_q);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: arm on starttrigger, fall back to WAIT on any mode change
    always_comb begin
        state_next = state;
        if (mode_changed) begin
            state_next = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: if (starttrigger) state_next = ST_RUN;
                ST_RUN:  state_next = ST_RUN;
                default: state_next = ST_WAIT;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        running = (state == ST_RUN);
    end

    assign y_last = add_line_q ? Y_LAST_ADD : Y_LAST_STD;

    // Raster counters: held at 0 outside RUN, so the first RUN clock is X=0,Y=0
    always_ff @(posedge clock) begin
        if (!reset || state != ST_RUN || state_next != ST_RUN) begin
            x <= '0;
            y <= '0;
        end else if (x == X_LAST) begin
            x <= '0;
            y <= (y == y_last) ? '0 : y + YW'(1);
        end else begin
            x <= x + XW'(1);
        end
    end

    // Stage 0: source pixel/line lookup and read address into the circular buffer
    always_comb begin
        dx        = int'(x) - H_OFFSET;
        dy        = int'(y) - V_OFFSET;
        sx        = dx >> pixel_repeat_q;
        sy        = dy >> line_doubler_q;
        in0       = (state == ST_RUN) && in_border(int'(x), int'(y));
        rdaddr    = '0;
        line_done = 1'b0;
        if (in0) begin
            rdaddr    = ADDR_BITS'((sy & (BUFFER_LINES - 1)) * SRC_LINE_WIDTH + sx);
            line_done = (sx == SRC_LINE_WIDTH - 1) &&
                        (!pixel_repeat_q || !dx[0]) &&
                        (!line_doubler_q || dy[0]);
        end
    end

    // Stages 1 and 2 track the RAM latency; a flush makes outputs idle next clock
    always_ff @(posedge clock) begin
        if (!reset || mode_changed) begin
            x1 <= '0;
            y1 <= '0;
            v1 <= 1'b0;
            x2 <= '0;
            y2 <= '0;
            v2 <= 1'b0;
        end else begin
            x1 <= x;
            y1 <= y;
            v1 <= (state == ST_RUN);
            x2 <= x1;
            y2 <= y1;
            v2 <= v1;
        end
    end

    // Stage 2 outputs: colour, syncs and frame markers aligned with rddata
    always_comb begin
        x2i    = int'(x2);
        y2i    = int'(y2);
        in2    = v2 && in_border(x2i, y2i);
        hs_act = v2 && (x2i >= H_SYNC_START) && (x2i < H_SYNC_START + H_SYNC_WIDTH);
        vs_act = v2 && (((y2i == V_SYNC_START) && (x2i >= H_SYNC_START)) ||
                        ((y2i > V_SYNC_START) && (y2i < V_SYNC_START + V_SYNC_WIDTH)) ||
                        ((y2i == V_SYNC_START + V_SYNC_WIDTH) && (x2i < H_SYNC_START)));
        hsync       = hs_act ? HSYNC_POL : ~HSYNC_POL;
        vsync       = vs_act ? VSYNC_POL : ~VSYNC_POL;
        DrawArea    = v2 && (x2i < H_VISIBLE) && (y2i < V_VISIBLE);
        frame_start = v2 && (x2i == 0) && (y2i == 0);
        red         = '0;
        green       = '0;
        blue        = '0;
`ifdef RAM2VIDEO_TESTPATTERN_EN
        bar     = (x2i - H_OFFSET) / BAR_W;
        bar_rgb = 3'b000;
        case (bar)
            0:       bar_rgb = 3'b111;
            1:       bar_rgb = 3'b110;
            2:       bar_rgb = 3'b011;
            3:       bar_rgb = 3'b010;
            4:       bar_rgb = 3'b101;
            5:       bar_rgb = 3'b100;
            6:       bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        if (in2 && test_mode) begin
            red   = {CW{bar_rgb[2]}};
            green = {CW{bar_rgb[1]}};
            blue  = {CW{bar_rgb[0]}};
        end else
`endif
        if (in2) begin
            red   = rddata[DATA_BITS-1 -: CW];
            green = rddata[DATA_BITS-CW-1 -: CW];
            blue  = rddata[CW-1:0];
        end
    end

endmodule

// File: tb/tb_ram2video_multimode.sv
// tb_ram2video_multimode
// Drives the reader with directed and random mode/trigger/reset sequences on a
// reduced raster, models the 2-clock line-buffer RAM, and checks every output
// each clock against a position-based reference model through a scoreboard.
module tb_ram2video_multimode;

    localparam int HV   = 40;
    localparam int HT   = 56;
    localparam int HSS  = 44;
    localparam int HSW  = 6;
    localparam int VV   = 12;
    localparam int VTOT = 16;
    localparam int VSS  = 13;
    localparam int VSW  = 2;
    localparam int HO   = 4;
    localparam int VO   = 1;
    localparam int SW   = 32;
    localparam int BL   = 4;
    localparam int AB   = 8;
    localparam int DB   = 24;
    localparam bit HP   = 1'b0;
    localparam bit VP   = 1'b1;

    logic          clock = 1'b0;
    logic          reset;
    logic          starttrigger;
    logic          pixel_repeat;
    logic          line_doubler;
    logic          add_line;
    logic [DB-1:0] rddata = '0;
    logic [DB-1:0] rd_p1  = '0;
    logic [AB-1:0] rdaddr;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic          hsync;
    logic          vsync;
    logic          DrawArea;
    logic          frame_start;
    logic          line_done;
    logic          running;
`ifdef RAM2VIDEO_TESTPATTERN_EN
    logic          test_mode = 1'b0;
`endif

    logic [DB-1:0] mem [0:(1<<AB)-1];

    typedef struct {
        logic [AB-1:0] rdaddr;
        logic          line_done;
        logic          running;
        logic [7:0]    red;
        logic [7:0]    green;
        logic [7:0]    blue;
        logic          hsync;
        logic          vsync;
        logic          draw;
        logic          frame_start;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   m_t    = -1;
    bit   m_run  = 1'b0;
    bit [2:0] m_mode = 3'b000;

    ram2video_multimode #(
        .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_VISIBLE(VV), .V_TOTAL(VTOT), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .H_OFFSET(HO), .V_OFFSET(VO), .SRC_LINE_WIDTH(SW), .BUFFER_LINES(BL),
        .ADDR_BITS(AB), .DATA_BITS(DB), .HSYNC_POL(HP), .VSYNC_POL(VP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .starttrigger(starttrigger),
        .pixel_repeat(pixel_repeat),
        .line_doubler(line_doubler),
        .add_line(add_line),
`ifdef RAM2VIDEO_TESTPATTERN_EN
        .test_mode(test_mode),
`endif
        .rddata(rddata),
        .rdaddr(rdaddr),
        .red(red),
        .green(green),
        .blue(blue),
        .hsync(hsync),
        .vsync(vsync),
        .DrawArea(DrawArea),
        .frame_start(frame_start),
        .line_done(line_done),
        .running(running)
    );

    always #5 clock = ~clock;

    // Line-buffer RAM with two clocks of read latency
    always @(posedge clock) begin
        rd_p1  <= mem[rdaddr];
        rddata <= rd_p1;
        cycle  <= cycle + 1;
    end

    function automatic bit inWindow(input int x, input int y);
        return x >= HO && x < HV - HO && y >= VO && y < VV - VO;
    endfunction

    // Buffer address of the source pixel shown at raster position (x, y)
    function automatic int pixelAddr(input int x, input int y, input bit pr, input bit ld);
        int sx;
        int sy;
        if (!inWindow(x, y)) return 0;
        sx = (x - HO) / (pr ? 2 : 1);
        sy = (y - VO) / (ld ? 2 : 1);
        return ((sy % BL) * SW + sx) % (1 << AB);
    endfunction

    // Expected outputs for a clock, given the run state, the number of clocks
    // since the raster started and the active mode {pixel_repeat, line_doubler, add_line}
    function automatic exp_t predict(input bit run, input int tt, input bit [2:0] mode);
        exp_t e;
        int   vt;
        int   x;
        int   y;
        int   x2;
        int   y2;
        int   p;
        bit   pr;
        bit   ld;
        logic [DB-1:0] d;
        pr = mode[2];
        ld = mode[1];
        vt = VTOT + int'(mode[0]);
        e.rdaddr      = '0;
        e.line_done   = 1'b0;
        e.running     = run;
        e.red         = '0;
        e.green       = '0;
        e.blue        = '0;
        e.hsync       = ~HP;
        e.vsync       = ~VP;
        e.draw        = 1'b0;
        e.frame_start = 1'b0;
        if (run) begin
            x = tt % HT;
            y = (tt / HT) % vt;
            e.rdaddr    = AB'(pixelAddr(x, y, pr, ld));
            e.line_done = inWindow(x, y) && ((x - HO) / (pr ? 2 : 1) == SW - 1) &&
                          (!pr || ((x - HO) % 2 == 0)) && (!ld || ((y - VO) % 2 == 1));
            if (tt >= 2) begin
                x2 = (tt - 2) % HT;
                y2 = ((tt - 2) / HT) % vt;
                p  = y2 * HT + x2;
                if (x2 >= HSS && x2 < HSS + HSW) e.hsync = HP;
                if (p >= VSS * HT + HSS && p < (VSS + VSW) * HT + HSS) e.vsync = VP;
                e.draw        = (x2 < HV) && (y2 < VV);
                e.frame_start = (x2 == 0) && (y2 == 0);
                if (inWindow(x2, y2)) begin
                    d       = mem[pixelAddr(x2, y2, pr, ld)];
                    e.red   = d[23:16];
                    e.green = d[15:8];
                    e.blue  = d[7:0];
                end
            end
        end
        return e;
    endfunction

    // Reference model: advance the run state at each edge and queue the expectation
    always @(posedge clock) begin
        bit [2:0] mode_now;
        mode_now = {pixel_repeat, line_doubler, add_line};
        if (!reset || mode_now != m_mode) begin
            m_run = 1'b0;
            m_t   = -1;
        end else if (!m_run) begin
            if (starttrigger) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else begin
            m_t = m_t + 1;
        end
        m_mode = mode_now;
        exp_q.push_back(predict(m_run, m_t, m_mode));
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, actual, expected);
        end
    endtask

    // Monitor: pop one expectation per clock and compare away from the edge
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("rdaddr",      32'(rdaddr),      32'(e.rdaddr));
            checkOutput("line_done",   32'(line_done),   32'(e.line_done));
            checkOutput("running",     32'(running),     32'(e.running));
            checkOutput("red",         32'(red),         32'(e.red));
            checkOutput("green",       32'(green),       32'(e.green));
            checkOutput("blue",        32'(blue),        32'(e.blue));
            checkOutput("hsync",       32'(hsync),       32'(e.hsync));
            checkOutput("vsync",       32'(vsync),       32'(e.vsync));
            checkOutput("DrawArea",    32'(DrawArea),    32'(e.draw));
            checkOutput("frame_start", 32'(frame_start), 32'(e.frame_start));
        end
    end

    task automatic applyStimulus(input logic rst, input logic trig, input logic pr,
                                 input logic ld, input logic al, input int cycles);
        reset        = rst;
        starttrigger = trig;
        pixel_repeat = pr;
        line_doubler = ld;
        add_line     = al;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = DB'($urandom);
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, HT * VTOT + 200);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2 * HT * VTOT + 100);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, HT * VTOT + 100);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, HT * VTOT + 100);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2 * HT * (VTOT + 1) + 100);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 300);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 400);
        for (int s = 0; s < 8; s++) begin
            logic [2:0] m;
            m = 3'($urandom_range(0, 7));
            applyStimulus(1'b1, 1'b0, m[2], m[1], m[0], $urandom_range(1, 4));
            applyStimulus(1'b1, 1'b1, m[2], m[1], m[0], $urandom_range(100, 700));
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b1, m[2], m[1], m[0], 1);
        end
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
